// File: rtl/adder_pkg.sv
// Shared types and defaults for the two-requester adder arbiter slice.
//   state_t   : controller state encoding (IDLE -> EXEC -> DONE)
//   ADD_WIDTH : default operand width of the shared adder
package adder_pkg;

  localparam int unsigned ADD_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/adder_arbiter_ctrl_if.sv
// Request/result bus between two requesters, a result consumer and the
// adder arbiter controller.
//   req0/a0/b0/gnt0 : requester 0 request, operands, one-cycle accept strobe
//   req1/a1/b1/gnt1 : requester 1 request, operands, one-cycle accept strobe
//   res_valid/res_ready/res_z/res_id : result valid/ready port, sum, source id
// master : requester/consumer side; slave : controller side.
interface adder_arbiter_ctrl_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH
);

  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             gnt0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt1;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH:0]   res_z;
  logic             res_id;

  modport master (
    output req0, a0, b0, req1, a1, b1, res_ready,
    input  gnt0, gnt1, res_valid, res_z, res_id
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1, res_ready,
    output gnt0, gnt1, res_valid, res_z, res_id
  );

endinterface

// File: rtl/adder_core.sv
// Combinational adder: z = a + b, one bit wider than the operands so the
// sum can never overflow.
//   a, b : WIDTH-bit operands
//   z    : WIDTH+1-bit sum
module adder_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   z
);

  always_comb begin
    z = {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/adder_arbiter_ctrl.sv
// Round-robin arbiter and sequencer sharing one adder between two requesters.
// A winner is granted in IDLE, its operands are captured, the add runs in
// EXEC, and the sum is held on a valid/ready port in DONE until consumed.
//   clk      : rising-edge clock
//   reset    : synchronous, active-low reset
//   ena      : low blocks new grants and holds EXEC
//   bus      : request/grant/result bus (slave side)
//   busy     : high whenever the controller is not in IDLE
//   op_count : completed result handshakes, wraps
module adder_arbiter_ctrl
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH     = ADD_WIDTH,
  parameter int unsigned CNT_W     = 8,
  parameter bit          PRIO_INIT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  adder_arbiter_ctrl_if.slave   bus,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  state_t           state;
  logic             ptr;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             id_reg;
  logic [WIDTH:0]   sum;

  adder_core #(.WIDTH(WIDTH)) u_add (
    .a (a_reg),
    .b (b_reg),
    .z (sum)
  );

  // Grants are combinational so the requester sees its accept in the same
  // cycle it is sampled; masked while reset is asserted so nothing is
  // accepted during reset.
  always_comb begin
    bus.gnt0 = 1'b0;
    bus.gnt1 = 1'b0;
    if (reset && ena && (state == ST_IDLE)) begin
      if (bus.req0 && bus.req1) begin
        bus.gnt0 = ~ptr;
        bus.gnt1 = ptr;
      end else begin
        bus.gnt0 = bus.req0;
        bus.gnt1 = bus.req1;
      end
    end
  end

  always_comb begin
    busy = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      ptr           <= PRIO_INIT;
      a_reg         <= '0;
      b_reg         <= '0;
      id_reg        <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_z     <= '0;
      bus.res_id    <= 1'b0;
      op_count      <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.gnt0 || bus.gnt1) begin
            a_reg  <= bus.gnt1 ? bus.a1 : bus.a0;
            b_reg  <= bus.gnt1 ? bus.b1 : bus.b0;
            id_reg <= bus.gnt1;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (ena) begin
            bus.res_z     <= sum;
            bus.res_id    <= id_reg;
            bus.res_valid <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          // Handshake completes independently of ena.
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            op_count      <= op_count + 1'b1;
            ptr           <= ~bus.res_id;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter_ctrl.sv
// Directed testbench for adder_arbiter_ctrl. Inputs change on the falling
// edge; outputs are sampled 1 time unit after the falling edge.
module tb_adder_arbiter_ctrl;

  logic       clk;
  logic       reset;
  logic       ena;
  logic       busy;
  logic [7:0] op_count;
  int         n_cmp;
  int         n_err;

  adder_arbiter_ctrl_if #(.WIDTH(4)) bus_if ();

  adder_arbiter_ctrl #(.WIDTH(4), .CNT_W(8), .PRIO_INIT(1'b0)) dut (
    .clk      (clk),
    .reset    (reset),
    .ena      (ena),
    .bus      (bus_if.slave),
    .busy     (busy),
    .op_count (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset;
    reset = 1'b0; ena = 1'b1;
    bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
    bus_if.a0 = 4'd1; bus_if.b0 = 4'd1; bus_if.a1 = 4'd2; bus_if.b1 = 4'd2;
    bus_if.res_ready = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (bus_if.gnt0 !== 1'b0) begin n_err++; $display("FAIL reset_gnt0 got %b exp 0", bus_if.gnt0); end
    n_cmp++; if (bus_if.gnt1 !== 1'b0) begin n_err++; $display("FAIL reset_gnt1 got %b exp 0", bus_if.gnt1); end
    n_cmp++; if (bus_if.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", bus_if.res_valid); end
    n_cmp++; if (op_count !== 8'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", op_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (bus_if.res_z !== 5'd0) begin n_err++; $display("FAIL reset_z got %0d exp 0", bus_if.res_z); end
    @(negedge clk);
    bus_if.req0 = 1'b0; bus_if.req1 = 1'b0; reset = 1'b1;
  endtask

  task automatic test_single;
    @(negedge clk);
    bus_if.req0 = 1'b1; bus_if.a0 = 4'd9; bus_if.b0 = 4'd7; #1;
    n_cmp++; if (bus_if.gnt0 !== 1'b1) begin n_err++; $display("FAIL single_gnt0 got %b exp 1", bus_if.gnt0); end
    n_cmp++; if (bus_if.gnt1 !== 1'b0) begin n_err++; $display("FAIL single_gnt1 got %b exp 0", bus_if.gnt1); end
    @(negedge clk);
    bus_if.req0 = 1'b0; bus_if.a0 = 4'd0; bus_if.b0 = 4'd0; #1;
    n_cmp++; if (bus_if.res_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_t1 got %b exp 0", bus_if.res_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy got %b exp 1", busy); end
    @(negedge clk); #1;
    n_cmp++; if (bus_if.res_valid !== 1'b1) begin n_err++; $display("FAIL single_valid_t2 got %b exp 1", bus_if.res_valid); end
    n_cmp++; if (bus_if.res_z !== 5'd16) begin n_err++; $display("FAIL single_z got %0d exp 16", bus_if.res_z); end
    n_cmp++; if (bus_if.res_id !== 1'b0) begin n_err++; $display("FAIL single_id got %b exp 0", bus_if.res_id); end
    bus_if.res_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus_if.res_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_done got %b exp 0", bus_if.res_valid); end
    n_cmp++; if (op_count !== 8'd1) begin n_err++; $display("FAIL single_count got %0d exp 1", op_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle got %b exp 0", busy); end
    bus_if.res_ready = 1'b0;
  endtask

  task automatic test_both;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    bus_if.req0 = 1'b1; bus_if.a0 = 4'd3; bus_if.b0 = 4'd4;
    bus_if.req1 = 1'b1; bus_if.a1 = 4'd15; bus_if.b1 = 4'd15; #1;
    n_cmp++; if (bus_if.gnt0 !== 1'b1) begin n_err++; $display("FAIL both_first_gnt0 got %b exp 1", bus_if.gnt0); end
    n_cmp++; if (bus_if.gnt1 !== 1'b0) begin n_err++; $display("FAIL both_first_gnt1 got %b exp 0", bus_if.gnt1); end
    @(negedge clk); #1;
    n_cmp++; if ((bus_if.gnt0 | bus_if.gnt1) !== 1'b0) begin n_err++; $display("FAIL both_exec_gnt got %b%b exp 00", bus_if.gnt0, bus_if.gnt1); end
    @(negedge clk); #1;
    n_cmp++; if (bus_if.res_z !== 5'd7) begin n_err++; $display("FAIL both_z0 got %0d exp 7", bus_if.res_z); end
    n_cmp++; if (bus_if.res_id !== 1'b0) begin n_err++; $display("FAIL both_id0 got %b exp 0", bus_if.res_id); end
    n_cmp++; if ((bus_if.gnt0 | bus_if.gnt1) !== 1'b0) begin n_err++; $display("FAIL both_done_gnt got %b%b exp 00", bus_if.gnt0, bus_if.gnt1); end
    bus_if.res_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus_if.gnt1 !== 1'b1) begin n_err++; $display("FAIL both_second_gnt1 got %b exp 1", bus_if.gnt1); end
    n_cmp++; if (bus_if.gnt0 !== 1'b0) begin n_err++; $display("FAIL both_second_gnt0 got %b exp 0", bus_if.gnt0); end
    bus_if.res_ready = 1'b0;
    @(negedge clk);
    bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus_if.res_z !== 5'd30) begin n_err++; $display("FAIL both_z1 got %0d exp 30", bus_if.res_z); end
    n_cmp++; if (bus_if.res_id !== 1'b1) begin n_err++; $display("FAIL both_id1 got %b exp 1", bus_if.res_id); end
    bus_if.res_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (op_count !== 8'd2) begin n_err++; $display("FAIL both_count got %0d exp 2", op_count); end
    bus_if.res_ready = 1'b0;
  endtask

  task automatic test_hold;
    @(negedge clk);
    bus_if.req0 = 1'b1; bus_if.a0 = 4'd5; bus_if.b0 = 4'd6;
    @(negedge clk);
    bus_if.req0 = 1'b0;
    @(negedge clk);
    bus_if.req1 = 1'b1; bus_if.a1 = 4'd1; bus_if.b1 = 4'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++; if (bus_if.res_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid[%0d] got %b exp 1", k, bus_if.res_valid); end
      n_cmp++; if (bus_if.res_z !== 5'd11) begin n_err++; $display("FAIL hold_z[%0d] got %0d exp 11", k, bus_if.res_z); end
      n_cmp++; if (bus_if.res_id !== 1'b0) begin n_err++; $display("FAIL hold_id[%0d] got %b exp 0", k, bus_if.res_id); end
      n_cmp++; if (bus_if.gnt1 !== 1'b0) begin n_err++; $display("FAIL hold_gnt1[%0d] got %b exp 0", k, bus_if.gnt1); end
      @(negedge clk);
    end
    bus_if.res_ready = 1'b1; bus_if.req1 = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus_if.res_valid !== 1'b0) begin n_err++; $display("FAIL hold_release got %b exp 0", bus_if.res_valid); end
    n_cmp++; if (op_count !== 8'd3) begin n_err++; $display("FAIL hold_count got %0d exp 3", op_count); end
    bus_if.res_ready = 1'b0;
  endtask

  task automatic test_ena;
    @(negedge clk);
    ena = 1'b0; bus_if.req0 = 1'b1; bus_if.a0 = 4'd1; bus_if.b0 = 4'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (bus_if.gnt0 !== 1'b0) begin n_err++; $display("FAIL ena_low_gnt0[%0d] got %b exp 0", k, bus_if.gnt0); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ena_low_busy[%0d] got %b exp 0", k, busy); end
      @(negedge clk);
    end
    ena = 1'b1; #1;
    n_cmp++; if (bus_if.gnt0 !== 1'b1) begin n_err++; $display("FAIL ena_high_gnt0 got %b exp 1", bus_if.gnt0); end
    @(negedge clk);
    ena = 1'b0; bus_if.req0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ena_exec_busy[%0d] got %b exp 1", k, busy); end
      n_cmp++; if (bus_if.res_valid !== 1'b0) begin n_err++; $display("FAIL ena_exec_valid[%0d] got %b exp 0", k, bus_if.res_valid); end
      @(negedge clk);
    end
    ena = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus_if.res_valid !== 1'b1) begin n_err++; $display("FAIL ena_valid got %b exp 1", bus_if.res_valid); end
    n_cmp++; if (bus_if.res_z !== 5'd3) begin n_err++; $display("FAIL ena_z got %0d exp 3", bus_if.res_z); end
    bus_if.res_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (op_count !== 8'd4) begin n_err++; $display("FAIL ena_count got %0d exp 4", op_count); end
    bus_if.res_ready = 1'b0;
  endtask

  task automatic test_reset_exec_wrap;
    @(negedge clk);
    bus_if.req1 = 1'b1; bus_if.a1 = 4'd2; bus_if.b1 = 4'd2;
    @(negedge clk);
    bus_if.req1 = 1'b0; reset = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus_if.res_valid !== 1'b0) begin n_err++; $display("FAIL rexec_valid got %b exp 0", bus_if.res_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rexec_busy got %b exp 0", busy); end
    n_cmp++; if (op_count !== 8'd0) begin n_err++; $display("FAIL rexec_count got %0d exp 0", op_count); end
    reset = 1'b1;
    for (int unsigned i = 0; i < 256; i++) begin
      @(negedge clk); bus_if.req0 = 1'b1; bus_if.a0 = 4'd8; bus_if.b0 = 4'd8;
      @(negedge clk); bus_if.req0 = 1'b0;
      @(negedge clk); bus_if.res_ready = 1'b1;
      @(negedge clk); bus_if.res_ready = 1'b0; #1;
      if (i == 32'd254) begin
        n_cmp++; if (op_count !== 8'd255) begin n_err++; $display("FAIL wrap_255 got %0d exp 255", op_count); end
      end
    end
    n_cmp++; if (op_count !== 8'd0) begin n_err++; $display("FAIL wrap_0 got %0d exp 0", op_count); end
    n_cmp++; if (bus_if.res_z !== 5'd16) begin n_err++; $display("FAIL wrap_z got %0d exp 16", bus_if.res_z); end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    reset = 1'b0; ena = 1'b1;
    bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
    bus_if.a0 = '0; bus_if.b0 = '0; bus_if.a1 = '0; bus_if.b1 = '0;
    bus_if.res_ready = 1'b0;
    test_reset();
    test_single();
    test_both();
    test_hold();
    test_ena();
    test_reset_exec_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
